// File: rtl/bram_dnsize_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_dnsize_fifo_pkg
// Description : Shared helpers for the BRAM downsizing FIFO: clog2, lane-order
//               constants and parameter legality predicates.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_dnsize_fifo_pkg;

  localparam int LANE_LSB_FIRST = 0;
  localparam int LANE_MSB_FIRST = 1;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // The write word must split into a power-of-two number of whole lanes.
  function automatic bit widths_legal(input int wr_w, input int rd_w);
    return (rd_w > 0) && (wr_w >= rd_w) && ((wr_w % rd_w) == 0) &&
           is_pow2(wr_w / rd_w);
  endfunction

  function automatic bit depth_legal(input int depth);
    return (depth >= 4) && is_pow2(depth);
  endfunction

  function automatic bit order_legal(input int order);
    return (order == LANE_LSB_FIRST) || (order == LANE_MSB_FIRST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_dnsize_fifo_sdp_ram_sync.sv
`default_nettype none
// ============================================================================
// Module      : sdp_ram_sync
// Description : Inferred simple-dual-port RAM, one write port and one read
//               port with a registered (1-cycle) read. No control logic.
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_ram_sync
  import bram_dnsize_fifo_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port: store on write enable.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: registered output, holds its value when no read is issued.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/bram_dnsize_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bram_dnsize_fifo
// Description : Single-clock FIFO on block RAM that accepts WR_WIDTH-bit words
//               and delivers them as RD_WIDTH-bit lanes, with valid/ready on
//               both sides, occupancy, full/empty, flush and lane order.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_dnsize_fifo
  import bram_dnsize_fifo_pkg::*;
#(
  parameter int WR_WIDTH   = 32,
  parameter int RD_WIDTH   = 8,
  parameter int DEPTH      = 1024,
  parameter int LANE_ORDER = LANE_LSB_FIRST
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        FLUSH,
  input  logic [WR_WIDTH-1:0]         DI,
  input  logic                        WR_VALID,
  output logic                        WR_READY,
  output logic [RD_WIDTH-1:0]         DO,
  output logic                        RD_VALID,
  input  logic                        RD_READY,
  output logic [clog2(DEPTH+3)-1:0]   LEVEL,
  output logic                        EMPTY,
  output logic                        FULL
);

  localparam int RATIO  = WR_WIDTH / RD_WIDTH;
  localparam int ADDR_W = clog2(DEPTH);
  localparam int CNT_W  = clog2(DEPTH + 1);
  localparam int LVL_W  = clog2(DEPTH + 3);
  localparam int LANE_W = (RATIO > 1) ? clog2(RATIO) : 1;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

  // --------------------------------------------------------------------------
  // Parameter legality, reported at elaboration
  // --------------------------------------------------------------------------
  if (!widths_legal(WR_WIDTH, RD_WIDTH)) begin : g_bad_ratio
    $error("bram_dnsize_fifo: WR_WIDTH/RD_WIDTH must be a power of two >= 1");
  end
  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("bram_dnsize_fifo: DEPTH must be a power of two >= 4");
  end
  if (!order_legal(LANE_ORDER)) begin : g_bad_order
    $error("bram_dnsize_fifo: LANE_ORDER must be 0 or 1");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0]    mem_count_q, mem_count_d;
  logic                inflight_q,  inflight_d;   // RAM read issued last cycle
  logic [1:0]          stg_cnt_q,   stg_cnt_d;    // output-stage occupancy 0..2
  logic [WR_WIDTH-1:0] stg0_q,      stg0_d;       // head word
  logic [WR_WIDTH-1:0] stg1_q,      stg1_d;       // second word
  logic [LANE_W-1:0]   lane_q,      lane_d;
  logic [RD_WIDTH-1:0] do_q,        do_d;
  logic                wr_ready_q,  wr_ready_d;

  logic                w_run;
  logic                w_wr_fire;
  logic                w_rd_hs;
  logic                w_pop;
  logic [2:0]          w_stage_load;
  logic                w_rd_issue;
  logic [WR_WIDTH-1:0] w_ram_rdata;
  logic [LVL_W-1:0]    w_level;

  // Select lane k of a word according to the configured lane order.
  function automatic logic [RD_WIDTH-1:0] lane_sel(input logic [WR_WIDTH-1:0] word,
                                                   input logic [LANE_W-1:0]   lane);
    logic [LANE_W-1:0] pos;
    pos = (LANE_ORDER == LANE_MSB_FIRST) ? (LAST_LANE - lane) : lane;
    return RD_WIDTH'(word >> (int'(pos) * RD_WIDTH));
  endfunction

  // --------------------------------------------------------------------------
  // Handshakes and RAM read issue
  // --------------------------------------------------------------------------
  // Flush and reset both suppress any same-cycle transfer.
  assign w_run     = RST_N && !FLUSH;
  assign w_wr_fire = w_run && WR_VALID && wr_ready_q;
  assign w_rd_hs   = w_run && (stg_cnt_q != 2'd0) && RD_READY;
  assign w_pop     = w_rd_hs && (lane_q == LAST_LANE);

  // Count the head leaving this cycle so a read can be issued into the slot it
  // frees; otherwise RATIO=1 would stall every third cycle.
  assign w_stage_load = 3'(stg_cnt_q) + 3'(inflight_q) - 3'(w_pop);
  assign w_rd_issue   = w_run && (mem_count_q != '0) && (w_stage_load < 3'd2);

  sdp_ram_sync #(
    .WIDTH  (WR_WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (w_wr_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (DI),
    .re_i    (w_rd_issue),
    .raddr_i (rd_ptr_q),
    .rdata_o (w_ram_rdata)
  );

  // --------------------------------------------------------------------------
  // Next-state: pointers, counts, output stage, lane serialiser
  // --------------------------------------------------------------------------
  // Pop the head first, then append the word returning from the RAM.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    stg0_d      = stg0_q;
    stg1_d      = stg1_q;
    stg_cnt_d   = stg_cnt_q;
    lane_d      = lane_q;

    if (w_wr_fire) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (w_rd_issue) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    mem_count_d = mem_count_q + CNT_W'(w_wr_fire) - CNT_W'(w_rd_issue);
    inflight_d  = w_rd_issue;

    if (w_pop) begin
      stg0_d    = stg1_q;
      stg_cnt_d = stg_cnt_q - 2'd1;
    end
    if (inflight_q) begin
      if (stg_cnt_d == 2'd0) begin
        stg0_d = w_ram_rdata;
      end else begin
        stg1_d = w_ram_rdata;
      end
      stg_cnt_d = stg_cnt_d + 2'd1;
    end

    if (w_rd_hs) begin
      lane_d = (lane_q == LAST_LANE) ? '0 : lane_q + LANE_W'(1);
    end

    wr_ready_d = (mem_count_d < DEPTH_CNT);
    do_d       = (stg_cnt_d != 2'd0) ? lane_sel(stg0_d, lane_d) : '0;
  end

  // State registers; reset and flush clear everything except RAM contents.
  always_ff @(posedge CLK) begin
    if (!RST_N || FLUSH) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      inflight_q  <= 1'b0;
      stg_cnt_q   <= 2'd0;
      stg0_q      <= '0;
      stg1_q      <= '0;
      lane_q      <= '0;
      do_q        <= '0;
      wr_ready_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      inflight_q  <= inflight_d;
      stg_cnt_q   <= stg_cnt_d;
      stg0_q      <= stg0_d;
      stg1_q      <= stg1_d;
      lane_q      <= lane_d;
      do_q        <= do_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, all derived from registered state
  // --------------------------------------------------------------------------
  // LEVEL counts words: RAM + in-flight read + output stage.
  assign w_level  = LVL_W'(mem_count_q) + LVL_W'(inflight_q) + LVL_W'(stg_cnt_q);

  assign WR_READY = wr_ready_q;
  assign DO       = do_q;
  assign RD_VALID = (stg_cnt_q != 2'd0);
  assign LEVEL    = w_level;
  assign EMPTY    = (w_level == '0);
  assign FULL     = (mem_count_q == DEPTH_CNT);

endmodule
`default_nettype wire

// File: tb/tb_bram_dnsize_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_dnsize_fifo
// Description : Scoreboard bench for bram_dnsize_fifo. Instance A is 32->8,
//               DEPTH=16, LSB-first; instance B is 32->8, DEPTH=4, MSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_dnsize_fifo;

  localparam int RATIO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n, flush, wv, rr;
  logic [31:0] di [2];
  wire  [1:0]  wr, rv, empty, full;
  wire  [7:0]  dout [2];
  wire  [4:0]  lvl_a;
  wire  [2:0]  lvl_b;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  q0 [$];
  logic [7:0]  q1 [$];
  logic [1:0]  chk_bubble = 2'b00;
  logic [1:0]  prev_stall = 2'b00;
  logic [7:0]  prev_do [2];
  int          lanes_seen [2] = '{0, 0};

  bram_dnsize_fifo #(.WR_WIDTH(32), .RD_WIDTH(8), .DEPTH(16), .LANE_ORDER(0)) u_a (
    .CLK(clk), .RST_N(rst_n[0]), .FLUSH(flush[0]), .DI(di[0]), .WR_VALID(wv[0]),
    .WR_READY(wr[0]), .DO(dout[0]), .RD_VALID(rv[0]), .RD_READY(rr[0]),
    .LEVEL(lvl_a), .EMPTY(empty[0]), .FULL(full[0]));

  bram_dnsize_fifo #(.WR_WIDTH(32), .RD_WIDTH(8), .DEPTH(4), .LANE_ORDER(1)) u_b (
    .CLK(clk), .RST_N(rst_n[1]), .FLUSH(flush[1]), .DI(di[1]), .WR_VALID(wv[1]),
    .WR_READY(wr[1]), .DO(dout[1]), .RD_VALID(rv[1]), .RD_READY(rr[1]),
    .LEVEL(lvl_b), .EMPTY(empty[1]), .FULL(full[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic note_spurious(input logic [7:0] act);
    total++;
    bad++;
    $display("FAIL lane_unexpected: actual=%0h expected=none", act);
  endtask

  // Expected-lane queues, one per instance.
  function automatic void qpush(input int k, input logic [7:0] v);
    if (k == 0) q0.push_back(v); else q1.push_back(v);
  endfunction
  function automatic logic [7:0] qpop(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction
  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction
  function automatic void qclear(input int k);
    if (k == 0) q0.delete(); else q1.delete();
  endfunction

  // Reference: a word becomes RATIO bytes, low byte first for A, high for B.
  function automatic void push_word(input int k, input logic [31:0] w);
    for (int i = 0; i < RATIO; i++) begin
      int pos;
      pos = (k == 1) ? (RATIO - 1 - i) : i;
      qpush(k, 8'(w >> (8 * pos)));
    end
  endfunction

  // Monitor: sample away from the rising edge; transfers seen here complete at
  // the next rising edge unless reset or flush is active.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n[k] || flush[k]) begin
        qclear(k);
        prev_stall[k] <= 1'b0;
      end else begin
        if (prev_stall[k] && rv[k])
          check("do_stable", 32'(dout[k]), 32'(prev_do[k]));
        if (rv[k] && rr[k]) begin
          lanes_seen[k] <= lanes_seen[k] + 1;
          if (qsize(k) == 0) note_spurious(dout[k]);
          else check("lane", 32'(dout[k]), 32'(qpop(k)));
        end
        if (chk_bubble[k] && qsize(k) >= 4 * RATIO)
          check("no_bubble", 32'(rv[k]), 32'd1);
        if (wv[k] && wr[k]) push_word(k, di[k]);
        prev_stall[k] <= rv[k] && !rr[k];
        prev_do[k]    <= dout[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int k, input logic [31:0] w);
    int n;
    n     = 0;
    di[k] = w;
    wv[k] = 1'b1;
    while (!wr[k] && n < 200) begin
      tick();
      n++;
    end
    check("put_ready", 32'(wr[k]), 32'd1);
    tick();
    wv[k] = 1'b0;
  endtask

  task automatic wait_empty(input int k, input int budget);
    for (int i = 0; i < budget && !empty[k]; i++) tick();
    check("drain_empty", 32'(empty[k]), 32'd1);
  endtask

  task automatic wait_valid(input int k, input int budget);
    for (int i = 0; i < budget && !rv[k]; i++) tick();
    check("wait_rd_valid", 32'(rv[k]), 32'd1);
  endtask

  task automatic check_reset(input int k, input string tag);
    check({tag, "_wr_ready"}, 32'(wr[k]), 32'd0);
    check({tag, "_rd_valid"}, 32'(rv[k]), 32'd0);
    check({tag, "_do"}, 32'(dout[k]), 32'd0);
    check({tag, "_level"}, (k == 0) ? 32'(lvl_a) : 32'(lvl_b), 32'd0);
    check({tag, "_empty"}, 32'(empty[k]), 32'd1);
    check({tag, "_full"}, 32'(full[k]), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int cyc;
    int seen0;
    rst_n = 2'b00; flush = 2'b00; wv = 2'b00; rr = 2'b00;
    di[0] = '0; di[1] = '0;
    tick(); tick();
    check_reset(0, "rst_a");
    check_reset(1, "rst_b");
    rst_n = 2'b11;
    tick();
    check("rel_wr_ready_a", 32'(wr[0]), 32'd1);
    check("rel_wr_ready_b", 32'(wr[1]), 32'd1);

    // LSB-first, first-word latency and lane order.
    rr[0] = 1'b1; di[0] = 32'h44332211; wv[0] = 1'b1;
    tick(); wv[0] = 1'b0;
    check("lat_e1_rd_valid", 32'(rv[0]), 32'd0);
    tick();
    check("lat_e2_rd_valid", 32'(rv[0]), 32'd0);
    tick();
    check("lat_e3_rd_valid", 32'(rv[0]), 32'd1);
    check("lat_first_lane", 32'(dout[0]), 32'h11);
    tick(); tick(); tick();
    check("lsb_last_lane", 32'(dout[0]), 32'h44);
    tick();
    check("lsb_empty", 32'(empty[0]), 32'd1);
    check("lsb_level", 32'(lvl_a), 32'd0);

    // MSB-first on B.
    rr[1] = 1'b1;
    put(1, 32'hA1B2C3D4);
    wait_empty(1, 50);

    // Fill B with the consumer stalled: 4 in RAM + 2 in the output stage.
    rr[1] = 1'b0; acc = 0;
    for (int i = 0; i < 7; i++) begin
      di[1] = $urandom; wv[1] = 1'b1;
      if (wr[1]) acc++;
      tick();
    end
    wv[1] = 1'b0;
    check("fill_accepted", 32'(acc), 32'd6);
    check("fill_full", 32'(full[1]), 32'd1);
    check("fill_wr_ready", 32'(wr[1]), 32'd0);
    check("fill_level", 32'(lvl_b), 32'd6);
    seen0 = lanes_seen[1];
    rr[1] = 1'b1;
    wait_empty(1, 200);
    check("fill_drained_lanes", 32'(lanes_seen[1] - seen0), 32'd24);

    // A: 100 back-to-back writes with random stalls, pointers wrap at 16.
    acc = 0; cyc = 0;
    while (acc < 100 && cyc < 5000) begin
      rr[0] = ($urandom_range(0, 3) != 0);
      di[0] = $urandom; wv[0] = 1'b1;
      if (wr[0]) acc++;
      tick(); cyc++;
    end
    wv[0] = 1'b0;
    check("rand_accepted", 32'(acc), 32'd100);
    for (int i = 0; i < 1000 && !empty[0]; i++) begin
      rr[0] = ($urandom_range(0, 3) != 0);
      tick();
    end
    check("rand_drained", 32'(empty[0]), 32'd1);

    // A: consumer always ready, no bubbles while data is queued.
    rr[0] = 1'b1; chk_bubble[0] = 1'b1; acc = 0; cyc = 0;
    while (acc < 40 && cyc < 2000) begin
      di[0] = $urandom; wv[0] = 1'b1;
      if (wr[0]) acc++;
      tick(); cyc++;
    end
    wv[0] = 1'b0;
    wait_empty(0, 400);
    chk_bubble[0] = 1'b0;

    // A: flush after two of four lanes.
    rr[0] = 1'b0;
    put(0, 32'h0d0c0b0a);
    put(0, 32'h1d1c1b1a);
    wait_valid(0, 20);
    check("flush_pre_lane", 32'(dout[0]), 32'h0a);
    rr[0] = 1'b1;
    tick(); tick();
    check("flush_third_lane", 32'(dout[0]), 32'h0c);
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0; rr[0] = 1'b0;
    check("flush_rd_valid", 32'(rv[0]), 32'd0);
    check("flush_level", 32'(lvl_a), 32'd0);
    check("flush_empty", 32'(empty[0]), 32'd1);
    put(0, 32'h44556677);
    wait_valid(0, 20);
    check("flush_new_lane", 32'(dout[0]), 32'h77);
    rr[0] = 1'b1;
    wait_empty(0, 50);

    // A: reset mid-stream with a simultaneous write.
    put(0, 32'h87654321);
    put(0, 32'hcafef00d);
    rst_n[0] = 1'b0; di[0] = 32'hdeadbeef; wv[0] = 1'b1;
    tick();
    check_reset(0, "mid_rst");
    rst_n[0] = 1'b1; wv[0] = 1'b0;
    tick();
    check("mid_rst_wr_ready", 32'(wr[0]), 32'd1);
    check("mid_rst_dropped", 32'(lvl_a), 32'd0);
    put(0, 32'h04030201);
    wait_valid(0, 20);
    check("mid_rst_first_lane", 32'(dout[0]), 32'h01);
    wait_empty(0, 50);

    tick(); tick();
    check("sb_left_a", 32'(qsize(0)), 32'd0);
    check("sb_left_b", 32'(qsize(1)), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
